// File: rtl/rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rec_play_ctrl
// Description : Record/playback control FSM with per-slot SRAM partitioning,
//               record-full stop and clamped speed/mode selection.
// Revision    : 1.0 - initial release
// ============================================================================
module rec_play_ctrl #(
    parameter  int ADDR_W    = 20,
    parameter  int NUM_SLOTS = 4,
    parameter  int SPEED_W   = 4,
    parameter  int SPEED_MAX = 8,
    localparam int c_SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_init_done,
    input  logic                 i_key_rec,
    input  logic                 i_key_play,
    input  logic                 i_key_stop,
    input  logic [c_SLOT_W-1:0]  i_slot_sel,
    input  logic [SPEED_W-1:0]   i_speed_sel,
    input  logic [1:0]           i_mode,
    input  logic [ADDR_W-1:0]    i_rec_addr,
    input  logic                 i_play_done,
    output logic                 o_i2c_start,
    output logic                 o_rec_start,
    output logic                 o_rec_pause,
    output logic                 o_rec_stop,
    output logic                 o_dsp_start,
    output logic                 o_dsp_pause,
    output logic                 o_dsp_stop,
    output logic                 o_sram_wr_sel,
    output logic [ADDR_W-1:0]    o_base_addr,
    output logic [ADDR_W-1:0]    o_end_addr,
    output logic [SPEED_W-1:0]   o_speed,
    output logic                 o_fast,
    output logic                 o_slow_0,
    output logic                 o_slow_1,
    output logic [2:0]           o_state,
    output logic [NUM_SLOTS-1:0] o_slot_valid
);

    localparam int                  c_SLOT_LOG   = $clog2(NUM_SLOTS);
    localparam int                  c_SLOT_SHIFT = ADDR_W - c_SLOT_LOG;
    localparam logic [c_SLOT_W-1:0] c_SLOT_LIM   = c_SLOT_W'(NUM_SLOTS - 1);
    localparam logic [ADDR_W-1:0]   c_SLOT_MASK  = {ADDR_W{1'b1}} >> c_SLOT_LOG;
    localparam logic [SPEED_W-1:0]  c_SPEED_MAX  = SPEED_W'(SPEED_MAX);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_I2C        = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_i2c_pend;
    logic [c_SLOT_W-1:0] r_slot;
    logic [ADDR_W-1:0]   r_end [NUM_SLOTS];

    function automatic logic [ADDR_W-1:0] base_of(input logic [c_SLOT_W-1:0] s);
        return ADDR_W'(s) << c_SLOT_SHIFT;
    endfunction

    logic [c_SLOT_W-1:0] w_slot_req;
    logic [ADDR_W-1:0]   w_base_act;
    logic [ADDR_W-1:0]   w_last_act;
    logic [SPEED_W-1:0]  w_speed;
    logic                w_key_stop, w_key_rec, w_key_play;
    logic                w_full, w_finish, w_play_go;

    // Key priority stop > rec > play: lower keys are dropped outright.
    assign w_key_stop = i_key_stop;
    assign w_key_rec  = i_key_rec & ~i_key_stop;
    assign w_key_play = i_key_play & ~i_key_stop & ~i_key_rec;

    assign w_slot_req = i_slot_sel & c_SLOT_LIM;
    assign w_base_act = base_of(r_slot);
    assign w_last_act = w_base_act | c_SLOT_MASK;
    assign w_speed    = (i_speed_sel == '0)         ? SPEED_W'(1) :
                        (i_speed_sel > c_SPEED_MAX) ? c_SPEED_MAX : i_speed_sel;

    assign w_full    = (r_state == S_RECD) && (i_rec_addr == w_last_act);
    assign w_finish  = w_full ||
                       (w_key_stop && ((r_state == S_RECD) || (r_state == S_RECD_PAUSE)));
    assign w_play_go = w_key_play &&
                       (((r_state == S_IDLE) && o_slot_valid[w_slot_req]) ||
                        (r_state == S_PLAY_PAUSE));

    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_I2C;
            r_i2c_pend    <= 1'b1;
            r_slot        <= '0;
            o_i2c_start   <= 1'b0;
            o_rec_start   <= 1'b0;
            o_rec_pause   <= 1'b0;
            o_rec_stop    <= 1'b0;
            o_dsp_start   <= 1'b0;
            o_dsp_pause   <= 1'b0;
            o_dsp_stop    <= 1'b0;
            o_sram_wr_sel <= 1'b0;
            o_base_addr   <= '0;
            o_end_addr    <= '0;
            o_speed       <= SPEED_W'(1);
            o_fast        <= 1'b0;
            o_slow_0      <= 1'b0;
            o_slow_1      <= 1'b0;
            o_slot_valid  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_end[i] <= '0;
            end
        end else begin
            o_rec_start <= 1'b0;
            o_rec_pause <= 1'b0;
            o_rec_stop  <= 1'b0;
            o_dsp_start <= 1'b0;
            o_dsp_pause <= 1'b0;
            o_dsp_stop  <= 1'b0;
            o_i2c_start <= r_i2c_pend;
            r_i2c_pend  <= 1'b0;

            // Speed and mode are sampled only on play start and resume.
            if (w_play_go) begin
                o_speed  <= w_speed;
                o_fast   <= (i_mode == 2'd1);
                o_slow_0 <= (i_mode == 2'd2);
                o_slow_1 <= (i_mode == 2'd3);
            end

            if (w_finish) begin
                r_state              <= S_IDLE;
                o_rec_stop           <= 1'b1;
                o_sram_wr_sel        <= 1'b0;
                r_end[r_slot]        <= i_rec_addr;
                o_end_addr           <= i_rec_addr;
                o_slot_valid[r_slot] <= (i_rec_addr != w_base_act);
            end else begin
                case (r_state)
                    S_I2C: begin
                        if (i_init_done) r_state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (w_key_rec) begin
                            r_slot        <= w_slot_req;
                            o_base_addr   <= base_of(w_slot_req);
                            o_end_addr    <= r_end[w_slot_req];
                            o_sram_wr_sel <= 1'b1;
                            o_rec_start   <= 1'b1;
                            r_state       <= S_RECD;
                        end else if (w_play_go) begin
                            r_slot      <= w_slot_req;
                            o_base_addr <= base_of(w_slot_req);
                            o_end_addr  <= r_end[w_slot_req];
                            o_dsp_start <= 1'b1;
                            r_state     <= S_PLAY;
                        end
                    end
                    S_RECD: begin
                        if (w_key_rec) begin
                            o_rec_pause <= 1'b1;
                            r_state     <= S_RECD_PAUSE;
                        end
                    end
                    S_RECD_PAUSE: begin
                        if (w_key_rec) begin
                            o_rec_start <= 1'b1;
                            r_state     <= S_RECD;
                        end
                    end
                    S_PLAY: begin
                        if (w_key_stop || i_play_done) begin
                            o_dsp_stop <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (w_key_play) begin
                            o_dsp_pause <= 1'b1;
                            r_state     <= S_PLAY_PAUSE;
                        end
                    end
                    S_PLAY_PAUSE: begin
                        if (w_key_stop) begin
                            o_dsp_stop <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (w_key_play) begin
                            o_dsp_start <= 1'b1;
                            r_state     <= S_PLAY;
                        end
                    end
                    default: r_state <= S_I2C;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rec_play_ctrl
// Description : Directed and randomized checks of rec_play_ctrl against a
//               rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rec_play_ctrl;

    localparam int c_SLOT_SZ = 32'h40000;

    logic        clk = 1'b0;
    logic        i_rst_n, i_init_done, i_key_rec, i_key_play, i_key_stop, i_play_done;
    logic [1:0]  i_slot_sel, i_mode;
    logic [3:0]  i_speed_sel;
    logic [19:0] i_rec_addr;
    logic        o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop;
    logic        o_dsp_start, o_dsp_pause, o_dsp_stop, o_sram_wr_sel;
    logic [19:0] o_base_addr, o_end_addr;
    logic [3:0]  o_speed, o_slot_valid;
    logic        o_fast, o_slow_0, o_slow_1;
    logic [2:0]  o_state;

    rec_play_ctrl #(.ADDR_W(20), .NUM_SLOTS(4), .SPEED_W(4), .SPEED_MAX(8)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_init_done(i_init_done),
        .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
        .i_slot_sel(i_slot_sel), .i_speed_sel(i_speed_sel), .i_mode(i_mode),
        .i_rec_addr(i_rec_addr), .i_play_done(i_play_done),
        .o_i2c_start(o_i2c_start), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
        .o_rec_stop(o_rec_stop), .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause),
        .o_dsp_stop(o_dsp_stop), .o_sram_wr_sel(o_sram_wr_sel),
        .o_base_addr(o_base_addr), .o_end_addr(o_end_addr), .o_speed(o_speed),
        .o_fast(o_fast), .o_slow_0(o_slow_0), .o_slow_1(o_slow_1),
        .o_state(o_state), .o_slot_valid(o_slot_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state numbers are the published output encodings.
    int          m_state, m_slot, m_speed;
    logic [1:0]  m_mode;
    logic [19:0] m_end [4];
    logic [3:0]  m_valid;
    logic        m_wr, m_first;
    logic        e_i2c, e_rs, e_rp, e_rt, e_ds, e_dp, e_dt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 1; m_slot = 0; m_speed = 1; m_mode = 2'd0;
        m_valid = 4'b0; m_wr = 1'b0; m_first = 1'b1;
        for (int i = 0; i < 4; i++) m_end[i] = 20'h0;
        {e_i2c, e_rs, e_rp, e_rt, e_ds, e_dp, e_dt} = 7'b0;
    endtask

    task automatic latch_play();
        m_speed = (i_speed_sel == 0) ? 1 : ((i_speed_sel > 8) ? 8 : int'(i_speed_sel));
        m_mode  = i_mode;
    endtask

    task automatic finish_rec();
        e_rt = 1'b1; m_wr = 1'b0; m_state = 0;
        m_end[m_slot]   = i_rec_addr;
        m_valid[m_slot] = (int'(i_rec_addr) != m_slot * c_SLOT_SZ);
    endtask

    task automatic model_step();
        logic ks, kr, kp, full;
        ks = i_key_stop;
        kr = i_key_rec && !ks;
        kp = i_key_play && !ks && !kr;
        {e_rs, e_rp, e_rt, e_ds, e_dp, e_dt} = 6'b0;
        e_i2c = m_first; m_first = 1'b0;
        full = (int'(i_rec_addr) == m_slot * c_SLOT_SZ + c_SLOT_SZ - 1);
        case (m_state)
            1: if (i_init_done) m_state = 0;
            0: begin
                if (kr) begin
                    m_slot = int'(i_slot_sel); m_state = 2; e_rs = 1'b1; m_wr = 1'b1;
                end else if (kp && m_valid[i_slot_sel]) begin
                    m_slot = int'(i_slot_sel); latch_play(); m_state = 4; e_ds = 1'b1;
                end
            end
            2: if (ks || full) finish_rec();
               else if (kr) begin m_state = 3; e_rp = 1'b1; end
            3: if (ks) finish_rec();
               else if (kr) begin m_state = 2; e_rs = 1'b1; end
            4: if (ks || i_play_done) begin m_state = 0; e_dt = 1'b1; end
               else if (kp) begin m_state = 5; e_dp = 1'b1; end
            5: if (ks) begin m_state = 0; e_dt = 1'b1; end
               else if (kp) begin latch_play(); m_state = 4; e_ds = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("state", 32'(o_state), 32'(m_state));
        chk("i2c_start", 32'(o_i2c_start), 32'(e_i2c));
        chk("rec_start", 32'(o_rec_start), 32'(e_rs));
        chk("rec_pause", 32'(o_rec_pause), 32'(e_rp));
        chk("rec_stop", 32'(o_rec_stop), 32'(e_rt));
        chk("dsp_start", 32'(o_dsp_start), 32'(e_ds));
        chk("dsp_pause", 32'(o_dsp_pause), 32'(e_dp));
        chk("dsp_stop", 32'(o_dsp_stop), 32'(e_dt));
        chk("sram_wr_sel", 32'(o_sram_wr_sel), 32'(m_wr));
        chk("base_addr", 32'(o_base_addr), 32'(m_slot * c_SLOT_SZ));
        chk("end_addr", 32'(o_end_addr), 32'(m_end[m_slot]));
        chk("speed", 32'(o_speed), 32'(m_speed));
        chk("fast", 32'(o_fast), 32'(m_mode == 2'd1));
        chk("slow_0", 32'(o_slow_0), 32'(m_mode == 2'd2));
        chk("slow_1", 32'(o_slow_1), 32'(m_mode == 2'd3));
        chk("slot_valid", 32'(o_slot_valid), 32'(m_valid));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic press(input logic r, input logic p, input logic s);
        i_key_rec = r; i_key_play = p; i_key_stop = s;
        tick();
        i_key_rec = 1'b0; i_key_play = 1'b0; i_key_stop = 1'b0;
    endtask

    task automatic async_reset();
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n = 1'b0; i_init_done = 1'b0; i_key_rec = 1'b0; i_key_play = 1'b0;
        i_key_stop = 1'b0; i_play_done = 1'b0; i_slot_sel = 2'd0; i_mode = 2'd0;
        i_speed_sel = 4'd0; i_rec_addr = 20'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        i_rst_n = 1'b1;

        // Ten cycles in codec init with random keys that must be ignored
        for (int i = 0; i < 10; i++) begin
            press(1'($urandom), 1'($urandom), 1'($urandom));
            chk("i2c_hold", 32'(o_state), 32'd1);
        end
        i_init_done = 1'b1;
        tick();
        chk("init_to_idle", 32'(o_state), 32'd0);

        // Slot 2 record with stop key
        i_slot_sel = 2'd2;
        press(1'b1, 1'b0, 1'b0);
        chk("slot2_base", 32'(o_base_addr), 32'h80000);
        for (int a = 32'h80000; a <= 32'h80100; a++) begin
            i_rec_addr = 20'(a);
            tick();
        end
        press(1'b0, 1'b0, 1'b1);
        chk("slot2_end", 32'(o_end_addr), 32'h80100);
        chk("slot2_valid", 32'(o_slot_valid), 32'h4);

        // Slot 0 record-full automatic stop
        i_slot_sel = 2'd0; i_rec_addr = 20'h10;
        press(1'b1, 1'b0, 1'b0);
        i_rec_addr = 20'h3FFFF;
        tick();
        chk("full_stop", 32'(o_rec_stop), 32'd1);
        chk("full_end", 32'(o_end_addr), 32'h3FFFF);

        // Play: empty slot ignored, then slot 2 with clamped speed
        i_slot_sel = 2'd1; i_speed_sel = 4'd12; i_mode = 2'd3;
        press(1'b0, 1'b1, 1'b0);
        chk("empty_play", 32'(o_dsp_start), 32'd0);
        i_slot_sel = 2'd2;
        press(1'b0, 1'b1, 1'b0);
        chk("play_speed", 32'(o_speed), 32'd8);
        chk("play_slow1", 32'(o_slow_1), 32'd1);
        chk("play_end", 32'(o_end_addr), 32'h80100);
        i_speed_sel = 4'd0; i_mode = 2'd1; i_slot_sel = 2'd0;
        tick();
        press(1'b0, 1'b1, 1'b0);
        chk("pause_state", 32'(o_state), 32'd5);
        press(1'b0, 1'b1, 1'b0);
        chk("resume_speed", 32'(o_speed), 32'd1);
        i_play_done = 1'b1;
        tick();
        i_play_done = 1'b0;
        chk("done_stop", 32'(o_dsp_stop), 32'd1);

        // Stop wins over rec in the same cycle
        i_slot_sel = 2'd1;
        press(1'b1, 1'b0, 1'b0);
        i_rec_addr = 20'h40020;
        tick();
        press(1'b1, 1'b0, 1'b1);
        chk("stop_wins_state", 32'(o_state), 32'd0);
        chk("stop_wins_end", 32'(o_end_addr), 32'h40020);

        // Zero-length recording in slot 3
        i_slot_sel = 2'd3;
        press(1'b1, 1'b0, 1'b0);
        i_rec_addr = 20'hC0000;
        press(1'b0, 1'b0, 1'b1);
        chk("zero_len_valid", 32'(o_slot_valid[3]), 32'd0);

        // Asynchronous reset mid-record: no stop strobe, valid bits cleared
        i_slot_sel = 2'd2;
        press(1'b1, 1'b0, 1'b0);
        tick();
        async_reset();
        chk("areset_valid", 32'(o_slot_valid), 32'd0);
        tick();

        // Randomized phase against the reference model
        for (int c = 0; c < 3000; c++) begin
            int sel;
            i_init_done = ($urandom_range(0, 3) != 0);
            i_slot_sel  = 2'($urandom_range(0, 3));
            i_speed_sel = 4'($urandom_range(0, 15));
            i_mode      = 2'($urandom_range(0, 3));
            i_play_done = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 7);
            i_rec_addr = 20'(m_slot * c_SLOT_SZ +
                             ((sel == 0) ? c_SLOT_SZ - 1 :
                              (sel == 1) ? 0 : $urandom_range(1, 1000)));
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                press(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 7) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Parametrised record/playback control FSM for the audio lab top level, replacing the ad-hoc control block.
- Sequences codec init, record, play and pause, and drives the start/pause/stop strobes to the recorder and DSP.
- Drives the SRAM direction select.
- Partitions SRAM into NUM_SLOTS equal track slots, each with its own stored end address.
- Adds per-slot playback, a record-full stop and clamped speed/mode selection.

Parameters:
- ADDR_W, 20: SRAM word-address width.
- NUM_SLOTS, 4: number of equal track slots; power of two, at least 1.
- SPEED_W, 4: speed-select width.
- SPEED_MAX, 8: largest legal speed factor.

Ports:
- i_clk  in  1  system clock (the BCLK domain in the top level).
- i_rst_n  in  1  asynchronous active-low reset.
- i_init_done  in  1  I2C initializer finished, level.
- i_key_rec  in  1  single-cycle debounced pulse: record / record-pause toggle.
- i_key_play  in  1  single-cycle pulse: play / play-pause toggle.
- i_key_stop  in  1  single-cycle pulse: stop.
- i_slot_sel  in  $clog2(NUM_SLOTS) (minimum 1)  requested slot.
- i_speed_sel  in  SPEED_W  requested speed factor.
- i_mode  in  2  play mode: 0 normal, 1 fast, 2 slow constant, 3 slow linear.
- i_rec_addr  in  ADDR_W  current recorder write address.
- i_play_done  in  1  DSP reached o_end_addr, pulse.
- o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  single-cycle strobes.
- o_sram_wr_sel  out  1  1 = SRAM driven by recorder (write), 0 = read.
- o_base_addr  out  ADDR_W  base address of the active slot.
- o_end_addr  out  ADDR_W  stored end address of the active slot.
- o_speed  out  SPEED_W  clamped speed.
- o_fast, o_slow_0, o_slow_1  out  1 each  decoded mode, one-hot or all zero.
- o_state  out  3  current state encoding.
- o_slot_valid  out  NUM_SLOTS  per-slot "has recording" bits.

Behaviour:
- State encodings: S_IDLE=0, S_I2C=1, S_RECD=2, S_RECD_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5.
- Reset:
  - State becomes S_I2C; all strobes, o_sram_wr_sel and mode outputs go to 0.
  - o_speed resets to 1; o_base_addr, o_end_addr, end-address array and o_slot_valid reset to 0.
  - Active slot register resets to 0.
- All outputs are registered. Each strobe is asserted for exactly the one cycle after the transition that causes it.
- Slot size is SLOT_SZ = 2^ADDR_W / NUM_SLOTS. For active slot s:
  - base(s) = s*SLOT_SZ.
  - last(s) = base(s) + SLOT_SZ - 1.
- Key priority when several keys arrive in the same cycle: stop > rec > play; the lower-priority keys are dropped.
- S_I2C:
  - o_i2c_start pulses on the first cycle after reset deassertion.
  - Stay until i_init_done = 1, then go to S_IDLE. All keys are ignored.
- S_IDLE, on key_rec:
  - Latch i_slot_sel into the active slot and go to S_RECD.
  - Pulse o_rec_start; o_sram_wr_sel goes to 1 in the same cycle.
  - o_base_addr = base(slot).
- S_IDLE, on key_play:
  - If o_slot_valid[i_slot_sel] = 1: latch slot, speed and mode; go to S_PLAY; pulse o_dsp_start.
  - Otherwise ignore the key and stay in S_IDLE.
- S_IDLE, key_stop: no effect.
- S_RECD:
  - key_rec → S_RECD_PAUSE, pulse o_rec_pause.
  - key_stop → S_IDLE, with the record-finish actions below.
  - i_rec_addr == last(slot) → S_IDLE, with the record-finish actions below (full stop, no key needed).
  - key_play is ignored.
- S_RECD_PAUSE:
  - key_rec → S_RECD, pulse o_rec_start.
  - key_stop → S_IDLE, with the record-finish actions below.
- Record-finish actions:
  - Pulse o_rec_stop; o_sram_wr_sel goes to 0.
  - Store end[slot] = i_rec_addr.
  - Set valid[slot] = 1 if i_rec_addr != base(slot); otherwise clear it (zero-length recording).
- Re-recording a valid slot overwrites its end address.
- S_PLAY:
  - key_play → S_PLAY_PAUSE, pulse o_dsp_pause.
  - key_stop or i_play_done → S_IDLE, pulse o_dsp_stop.
  - key_rec is ignored.
- S_PLAY_PAUSE:
  - key_play → S_PLAY, pulse o_dsp_start.
  - Speed and mode are re-latched on this resume.
  - key_stop → S_IDLE, pulse o_dsp_stop.
- Speed clamp: 0 maps to 1; values above SPEED_MAX map to SPEED_MAX.
- Mode decode: mode 0 gives all zero; modes 1, 2, 3 assert o_fast, o_slow_0, o_slow_1 respectively.
- Speed, mode and slot stay constant while in S_PLAY.
- o_end_addr always shows end[active slot].
- Asynchronous reset mid-record or mid-play:
  - Return to S_I2C and clear all valid bits.
  - No stop strobe is emitted.

Test Plan:
- Reset release with i_init_done rising 10 cycles later → one o_i2c_start pulse in cycle 1; o_state = 1 for 10 cycles, then 0; keys pressed during S_I2C are ignored.
- Slot 2 (ADDR_W=20, NUM_SLOTS=4): key_rec, i_rec_addr ramps to 0x80100, key_stop → o_rec_start at base 0x80000, o_rec_stop one cycle after stop, end[2] = 0x80100, o_slot_valid = 4'b0100.
- Recording in slot 0 reaches i_rec_addr = 0x3FFFF with no key → automatic o_rec_stop, state 0, end[0] = 0x3FFFF.
- key_play on slot 1 (empty) → no o_dsp_start, state stays 0. key_play on slot 2 with i_speed_sel = 12, i_mode = 3 → o_dsp_start, o_speed = 8, o_slow_1 = 1, o_end_addr = 0x80100.
- In S_PLAY: key_play → o_dsp_pause, state 5. key_play again → o_dsp_start, state 4. i_play_done → o_dsp_stop, state 0.
- key_rec and key_stop in the same cycle while in S_RECD → stop wins: S_IDLE, end stored. Zero-length record (stop immediately, i_rec_addr = base) → valid bit stays 0.
